vls_mem_responder: RTL

Memory-side responder for the vector load/store unit (`vls`). It accepts dual-lane (a/b) load and store requests and arbitrates them round-robin onto a single-ported row-organised scratchpad. Load data returns per lane through credit-limited response FIFOs, with a `ready_in`-style backpressure handshake. It sits between `vls` and the vector scratchpad, and stands in for that scratchpad in `vls`-level benches.

---
 rtl/vls_mem_pkg.sv | 47 ++++
 rtl/vls_rsp_fifo.sv | 65 ++++++
 rtl/vls_mem_responder.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/vls_mem_pkg.sv
// ============================================================================
// vls_mem_pkg : shared types and helpers for the vls memory responder
// Rev 1.0
// ============================================================================
`default_nettype none

package vls_mem_pkg;

    localparam int C_DATA_W = 32;
    localparam int C_LANES  = 4;
    localparam int C_ROWS   = 256;
    localparam int C_ROW_W  = $clog2(C_ROWS);
    localparam int C_OFS_W  = $clog2(C_LANES * C_DATA_W / 8);

    typedef logic [C_LANES*C_DATA_W-1:0] row_data_t;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic               wen;
        logic [C_ROW_W-1:0] row;
        row_data_t          wdata;
        logic               id;
    } mem_req_t;

    typedef struct packed {
        row_data_t rdata;
        logic      id;
        logic      store;
    } mem_rsp_t;

    typedef struct packed {
        mem_rsp_t rsp;
        logic     port;
    } pipe_entry_t;

    // Byte address to row: drop the in-row offset, wrap the high bits.
    function automatic logic [C_ROW_W-1:0] addr_to_row(input logic [31:0] addr);
        return addr[C_OFS_W +: C_ROW_W];
    endfunction

endpackage

`default_nettype wire

// File: rtl/vls_rsp_fifo.sv
// ============================================================================
// vls_rsp_fifo : per-port response FIFO with occupancy output for credits
// Rev 1.0
// ============================================================================
`default_nettype none

module vls_rsp_fifo
    import vls_mem_pkg::*;
#(
    parameter int  FIFO_DEPTH = 4,
    parameter type T          = mem_rsp_t
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_push,
    input  T                            i_data,
    input  logic                        i_pop,
    output logic                        o_valid,
    output T                            o_data,
    output logic [$clog2(FIFO_DEPTH):0] o_count
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);

    T                   r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr;
    logic [c_PTR_W-1:0] r_rd;
    logic [c_PTR_W:0]   r_count;
    logic               w_pop;

    assign o_valid = (r_count != '0);
    assign w_pop   = i_pop && o_valid;
    assign o_count = r_count;
    // Head is forced to zero when empty so outputs read 0 out of reset.
    assign o_data  = o_valid ? r_mem[r_rd] : '0;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/vls_mem_responder.sv
// ============================================================================
// vls_mem_responder : dual-lane round-robin scratchpad responder for vls.
// Optional perf counters via VLS_MEM_PERF_CNT_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module vls_mem_responder
    import vls_mem_pkg::*;
#(
    parameter int DATA_W     = C_DATA_W,
    parameter int LANES      = C_LANES,
    parameter int ROWS       = C_ROWS,
    parameter int LAT        = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    req_valid_a,
    output logic                    req_ready_a,
    input  logic                    req_wen_a,
    input  logic [31:0]             req_addr_a,
    input  logic [LANES*DATA_W-1:0] req_wdata_a,
    input  logic                    req_id_a,
    input  logic                    req_valid_b,
    output logic                    req_ready_b,
    input  logic                    req_wen_b,
    input  logic [31:0]             req_addr_b,
    input  logic [LANES*DATA_W-1:0] req_wdata_b,
    input  logic                    req_id_b,
    output logic                    rsp_valid_a,
    input  logic                    rsp_ready_a,
    output logic [LANES*DATA_W-1:0] rsp_rdata_a,
    output logic                    rsp_id_a,
    output logic                    rsp_store_a,
    output logic                    rsp_valid_b,
    input  logic                    rsp_ready_b,
    output logic [LANES*DATA_W-1:0] rsp_rdata_b,
    output logic                    rsp_id_b,
    output logic                    rsp_store_b,
    output logic                    init_done
`ifdef VLS_MEM_PERF_CNT_EN
    ,
    output logic [31:0]             perf_loads,
    output logic [31:0]             perf_stores
`endif
);

    localparam int c_ROW_W = $clog2(ROWS);
    localparam int c_W     = LANES * DATA_W;
    localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int c_OCC_W = $clog2(LAT + FIFO_DEPTH + 1) + 1;

    mem_state_t         r_state;
    mem_state_t         w_state_nxt;
    logic [c_ROW_W-1:0] r_cnt;
    logic               w_run;

    logic               r_rr;
    logic [c_OCC_W-1:0] w_infl_a, w_infl_b;
    logic [c_CNT_W-1:0] w_fcnt_a, w_fcnt_b;
    logic               w_elig_a, w_elig_b, w_gnt_a, w_gnt_b, w_acc;
    mem_req_t           w_req;
    pipe_entry_t        w_ent;

    logic [c_W-1:0]     r_mem [ROWS];
    pipe_entry_t        r_pe [LAT];
    logic [LAT-1:0]     r_pv;
    logic               w_push_a, w_push_b;
    mem_rsp_t           w_head_a, w_head_b;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= (r_state == ST_INIT) ? r_cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_INIT && r_cnt == c_ROW_W'(ROWS - 1)) begin
            w_state_nxt = ST_RUN;
        end
    end

    always_comb begin
        w_run     = (r_state == ST_RUN);
        init_done = w_run;
    end

    // ------------------------------------------------- credits / arbitration
    // A port's credit covers everything it may still receive: pipeline + FIFO.
    always_comb begin
        w_infl_a = '0;
        w_infl_b = '0;
        for (int i = 0; i < LAT; i++) begin
            if (r_pv[i] && !r_pe[i].port) w_infl_a = w_infl_a + c_OCC_W'(1);
            if (r_pv[i] &&  r_pe[i].port) w_infl_b = w_infl_b + c_OCC_W'(1);
        end
    end

    assign w_elig_a = req_valid_a && w_run &&
                      ((w_infl_a + c_OCC_W'(w_fcnt_a)) < c_OCC_W'(FIFO_DEPTH));
    assign w_elig_b = req_valid_b && w_run &&
                      ((w_infl_b + c_OCC_W'(w_fcnt_b)) < c_OCC_W'(FIFO_DEPTH));
    assign w_gnt_a  = w_elig_a && (!w_elig_b || !r_rr);
    assign w_gnt_b  = w_elig_b && (!w_elig_a ||  r_rr);
    assign w_acc    = w_gnt_a || w_gnt_b;

    assign req_ready_a = w_gnt_a;
    assign req_ready_b = w_gnt_b;

    always_comb begin
        w_req.wen   = w_gnt_b ? req_wen_b   : req_wen_a;
        w_req.row   = addr_to_row(w_gnt_b ? req_addr_b : req_addr_a);
        w_req.wdata = w_gnt_b ? req_wdata_b : req_wdata_a;
        w_req.id    = w_gnt_b ? req_id_b    : req_id_a;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_rr <= 1'b0;
        end else if (w_gnt_a) begin
            r_rr <= 1'b1;
        end else if (w_gnt_b) begin
            r_rr <= 1'b0;
        end
    end

    // ------------------------------------------------------ memory + pipe
    always_ff @(posedge CLK) begin
        if (!w_run) begin
            r_mem[r_cnt] <= '0;
        end else if (w_acc && w_req.wen) begin
            r_mem[w_req.row] <= w_req.wdata;
        end
    end

    always_comb begin
        w_ent.port      = w_gnt_b;
        w_ent.rsp.id    = w_req.id;
        w_ent.rsp.store = w_req.wen;
        w_ent.rsp.rdata = w_req.wen ? '0 : r_mem[w_req.row];
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_pv <= '0;
            for (int i = 0; i < LAT; i++) r_pe[i] <= '0;
        end else begin
            r_pv[0] <= w_acc;
            r_pe[0] <= w_ent;
            for (int i = 1; i < LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pe[i] <= r_pe[i-1];
            end
        end
    end

    assign w_push_a = r_pv[LAT-1] && !r_pe[LAT-1].port;
    assign w_push_b = r_pv[LAT-1] &&  r_pe[LAT-1].port;

    vls_rsp_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .T(mem_rsp_t)) u_fifo_a (
        .clk     (CLK),
        .rst_n   (nRST),
        .i_push  (w_push_a),
        .i_data  (r_pe[LAT-1].rsp),
        .i_pop   (rsp_ready_a),
        .o_valid (rsp_valid_a),
        .o_data  (w_head_a),
        .o_count (w_fcnt_a)
    );

    vls_rsp_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .T(mem_rsp_t)) u_fifo_b (
        .clk     (CLK),
        .rst_n   (nRST),
        .i_push  (w_push_b),
        .i_data  (r_pe[LAT-1].rsp),
        .i_pop   (rsp_ready_b),
        .o_valid (rsp_valid_b),
        .o_data  (w_head_b),
        .o_count (w_fcnt_b)
    );

    assign rsp_rdata_a = w_head_a.rdata;
    assign rsp_id_a    = w_head_a.id;
    assign rsp_store_a = w_head_a.store;
    assign rsp_rdata_b = w_head_b.rdata;
    assign rsp_id_b    = w_head_b.id;
    assign rsp_store_b = w_head_b.store;

`ifdef VLS_MEM_PERF_CNT_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            perf_loads  <= '0;
            perf_stores <= '0;
        end else if (w_acc) begin
            if (w_req.wen) begin
                if (perf_stores != '1) perf_stores <= perf_stores + 1'b1;
            end else begin
                if (perf_loads != '1) perf_loads <= perf_loads + 1'b1;
            end
        end
    end
`endif

endmodule

`default_nettype wire
